// File: rtl/bus_sequencer.sv
// bus_sequencer: Moore FSM sequencing one fetch/execute pass over a
// single-bus datapath (T0-T5 with a bounded memory wait and an error exit).
//
// Ports:
//   clock      - single clock, all state changes on rising edge
//   clear      - synchronous active-low reset
//   start      - request one fetch/execute sequence (honoured in IDLE only)
//   mem_ready  - memory read data valid (looked at in MEMWAIT only)
//   ir         - instruction register: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   out_sel    - one-hot bus source: 0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh,
//                19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C
//   reg_in     - one-hot R0-R15 load enable
//   PCin..Read - datapath strobes
//   alu_op     - ALU operation code
//   busy/done/error - status
module bus_sequencer #(
    parameter int wordSize = 32
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [wordSize-1:0] ir,
    output logic [23:0]         out_sel,
    output logic [15:0]         reg_in,
    output logic                PCin,
    output logic                IRin,
    output logic                MARin,
    output logic                MDRin,
    output logic                Yin,
    output logic                Zin,
    output logic                IncPC,
    output logic                Read,
    output logic [4:0]          alu_op,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        MEMWAIT,
        T2,
        T3,
        T4,
        T5,
        ERR
    } state_t;

    localparam logic [4:0] OP_MAX = 5'd11;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;

    // Only the decoded fields matter; the rest of the word is don't-care.
    logic unused_ir;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir;

    always_ff @(posedge clock) begin
        if (!clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        out_sel      = '0;
        reg_in       = '0;
        PCin         = 1'b0;
        IRin         = 1'b0;
        MARin        = 1'b0;
        MDRin        = 1'b0;
        Yin          = 1'b0;
        Zin          = 1'b0;
        IncPC        = 1'b0;
        Read         = 1'b0;
        alu_op       = '0;
        done         = 1'b0;
        error        = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_nxt = T0;
            end
            T0: begin
                out_sel[20] = 1'b1;
                MARin       = 1'b1;
                IncPC       = 1'b1;
                Zin         = 1'b1;
                state_nxt   = T1;
            end
            T1: begin
                out_sel[19]  = 1'b1;
                PCin         = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = MEMWAIT;
            end
            MEMWAIT: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                // wait_cnt == 15 here means this is the 16th idle cycle
                if (mem_ready) begin
                    state_nxt = T2;
                end else if (wait_cnt == 4'd15) begin
                    state_nxt = ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            T2: begin
                out_sel[21] = 1'b1;
                IRin        = 1'b1;
                state_nxt   = T3;
            end
            T3: begin
                out_sel[rb] = 1'b1;
                Yin         = 1'b1;
                state_nxt   = (opcode <= OP_MAX) ? T4 : ERR;
            end
            T4: begin
                out_sel[rc] = 1'b1;
                Zin         = 1'b1;
                alu_op      = opcode;
                state_nxt   = T5;
            end
            T5: begin
                out_sel[19] = 1'b1;
                reg_in[ra]  = 1'b1;
                done        = 1'b1;
                state_nxt   = IDLE;
            end
            ERR: begin
                error     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: table-driven per-cycle check of bus_sequencer.
// Each record drives one cycle's inputs and the outputs expected then.
module tb_bus_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic [23:0] out_sel;
  logic [15:0] reg_in;
  logic        PCin, IRin, MARin, MDRin;
  logic        Yin, Zin, IncPC, Read;
  logic [4:0]  alu_op;
  logic        busy, done, error;

  int n_checks = 0;
  int n_fail   = 0;

  bus_sequencer #(.wordSize(32)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .mem_ready(mem_ready),
    .ir       (ir),
    .out_sel  (out_sel),
    .reg_in   (reg_in),
    .PCin     (PCin),
    .IRin     (IRin),
    .MARin    (MARin),
    .MDRin    (MDRin),
    .Yin      (Yin),
    .Zin      (Zin),
    .IncPC    (IncPC),
    .Read     (Read),
    .alu_op   (alu_op),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic        st;
    logic        mr;
    logic [31:0] ir;
    logic [23:0] sel;
    logic [15:0] rg;
    logic [7:0]  sb;
    logic [4:0]  alu;
    logic [2:0]  stat;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] cur_ir;

  task automatic v(input logic clr, input logic st,
                   input logic mr,
                   input logic [23:0] sel,
                   input logic [15:0] rg,
                   input logic [7:0] sb,
                   input logic [4:0] alu,
                   input logic [2:0] stat);
    vec_t r;
    r.clr = clr; r.st = st; r.mr = mr;
    r.ir = cur_ir;
    r.sel = sel; r.rg = rg; r.sb = sb;
    r.alu = alu; r.stat = stat;
    vq.push_back(r);
  endtask

  task automatic v_idle(input logic clr, input logic st);
    v(clr, st, 1'b0, 24'h0, 16'h0, 8'h00, 5'd0, 3'b000);
  endtask
  task automatic v_t0(input logic st, input logic mr);
    v(1'b1, st, mr, 24'h100000, 16'h0, 8'h26, 5'd0, 3'b100);
  endtask
  task automatic v_t1(input logic st, input logic mr);
    v(1'b1, st, mr, 24'h080000, 16'h0, 8'h80, 5'd0, 3'b100);
  endtask
  task automatic v_mw(input logic st, input logic mr);
    v(1'b1, st, mr, 24'h0, 16'h0, 8'h11, 5'd0, 3'b100);
  endtask
  task automatic v_t2(input logic st);
    v(1'b1, st, 1'b0, 24'h200000, 16'h0, 8'h40, 5'd0, 3'b100);
  endtask
  task automatic v_t3(input logic st, input logic [23:0] sel);
    v(1'b1, st, 1'b0, sel, 16'h0, 8'h08, 5'd0, 3'b100);
  endtask
  task automatic v_t4(input logic st, input logic [23:0] sel,
                      input logic [4:0] alu);
    v(1'b1, st, 1'b0, sel, 16'h0, 8'h04, alu, 3'b100);
  endtask
  task automatic v_t5(input logic st, input logic [15:0] rg);
    v(1'b1, st, 1'b0, 24'h080000, rg, 8'h00, 5'd0, 3'b110);
  endtask
  task automatic v_err(input logic st);
    v(1'b1, st, 1'b0, 24'h0, 16'h0, 8'h00, 5'd0, 3'b101);
  endtask

  task automatic add_ok(input logic st);
    v_t0(st, 1'b0); v_t1(st, 1'b0); v_mw(st, 1'b1); v_t2(st);
    v_t3(st, 24'h2); v_t4(st, 24'h4, 5'd0); v_t5(st, 16'h8);
  endtask

  logic [55:0] got;
  logic [55:0] want;

  initial begin
    clear = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = '0;
    cur_ir = '0;

    v(1'b0, 1'b1, 1'b1, 24'h0, 16'h0, 8'h00, 5'd0, 3'b000);

    cur_ir = 32'h0188_8000;
    v_idle(1, 1);
    v_t0(0, 0); v_t1(0, 0); v_mw(0, 1); v_t2(0);
    v_t3(0, 24'h2); v_t4(0, 24'h2, 5'd0); v_t5(0, 16'h8);
    v_idle(1, 0);

    cur_ir = 32'h0189_0000;
    v_idle(1, 1); add_ok(0); v_idle(1, 0);

    cur_ir = 32'h5800_0000;
    v_idle(1, 1);
    v_t0(0, 0); v_t1(0, 0); v_mw(0, 1); v_t2(0);
    v_t3(0, 24'h1); v_t4(0, 24'h1, 5'd11); v_t5(0, 16'h1);
    v_idle(1, 0);

    cur_ir = 32'h1ABD_0000;
    v_idle(1, 1);
    v_t0(0, 1); v_t1(0, 1);
    for (int i = 0; i < 5; i++) v_mw(0, 0);
    v_mw(0, 1); v_t2(1);
    v_t3(0, 24'h80); v_t4(0, 24'h400, 5'd3); v_t5(0, 16'h20);
    v_idle(1, 0);

    cur_ir = 32'h0189_0000;
    v_idle(1, 1); v_t0(0, 0); v_t1(0, 0);
    for (int i = 0; i < 16; i++) v_mw(0, 0);
    v_err(1);
    v_idle(1, 1); add_ok(0); v_idle(1, 0);

    v_idle(1, 1); v_t0(0, 0); v_t1(0, 0);
    for (int i = 0; i < 15; i++) v_mw(0, 0);
    v_mw(0, 1); v_t2(0);
    v_t3(0, 24'h2); v_t4(0, 24'h4, 5'd0); v_t5(0, 16'h8);
    v_idle(1, 0);

    cur_ir = 32'hA7FF_8000;
    v_idle(1, 1); v_t0(0, 0); v_t1(0, 0); v_mw(0, 1); v_t2(0);
    v_t3(0, 24'h8000); v_err(0); v_idle(1, 0);

    cur_ir = 32'h6000_0000;
    v_idle(1, 1); v_t0(0, 0); v_t1(0, 0); v_mw(0, 1); v_t2(0);
    v_t3(0, 24'h1); v_err(0); v_idle(1, 0);

    cur_ir = 32'h0189_0000;
    v_idle(1, 1); v_t0(0, 0); v_t1(0, 0); v_mw(0, 1); v_t2(0);
    v_t3(0, 24'h2);
    v(1'b0, 1'b1, 1'b1, 24'h4, 16'h0, 8'h04, 5'd0, 3'b100);
    v_idle(1, 1); add_ok(0); v_idle(1, 0);

    v_idle(1, 1); v_t0(0, 0); v_t1(0, 0);
    for (int i = 0; i < 5; i++) v_mw(0, 0);
    v(1'b0, 1'b1, 1'b1, 24'h0, 16'h0, 8'h11, 5'd0, 3'b100);
    v_idle(1, 1); v_t0(0, 0); v_t1(0, 0);
    for (int i = 0; i < 15; i++) v_mw(0, 0);
    v_mw(0, 1); v_t2(0);
    v_t3(0, 24'h2); v_t4(0, 24'h4, 5'd0); v_t5(0, 16'h8);
    v_idle(1, 0);

    v_idle(1, 1); add_ok(1);
    v_idle(1, 1); add_ok(0); v_idle(1, 0);

    repeat (2) @(posedge clock);

    foreach (vq[i]) begin
      @(negedge clock);
      clear     = vq[i].clr;
      start     = vq[i].st;
      mem_ready = vq[i].mr;
      ir        = vq[i].ir;
      #1;
      got  = {out_sel, reg_in,
              PCin, IRin, MARin, MDRin,
              Yin, Zin, IncPC, Read,
              alu_op, busy, done, error};
      want = {vq[i].sel, vq[i].rg, vq[i].sb,
              vq[i].alu, vq[i].stat};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL vec%0d: got sel=%h reg=%h strb=%b alu=%0d bde=%b, want sel=%h reg=%h strb=%b alu=%0d bde=%b",
                 i, got[55:32], got[31:16], got[15:8],
                 got[7:3], got[2:0],
                 want[55:32], want[31:16], want[15:8],
                 want[7:3], want[2:0]);
      end
      if (i > 0 && !vq[i-1].clr) begin
        n_checks++;
        if (got !== 56'h0) begin
          n_fail++;
          $display("FAIL reset vec%0d: outputs not 0 after clear: %h",
                   i, got);
        end
      end
      if (vq[i].stat == 3'b101) begin
        n_checks++;
        if (error !== 1'b1 || done !== 1'b0 ||
            busy !== 1'b1 || reg_in !== 16'h0) begin
          n_fail++;
          $display("FAIL err vec%0d: bde=%b%b%b reg=%h",
                   i, busy, done, error, reg_in);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
